up_counter_tc: RTL and testbench

//   Loadable W-bit up counter; the count-up counterpart of the 4-bit down counter.

---
 rtl/upcnt_pkg.sv | 12 +
 rtl/upcnt_prescaler.sv | 34 +++
 rtl/up_counter_tc.sv | 103 ++++++++++
 tb/tb_up_counter_tc.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/upcnt_pkg.sv
// Shared types and defaults for the loadable up counter with terminal-count flags.
package upcnt_pkg;

  localparam int unsigned UpcntDefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } upcnt_state_t;

endpackage

// File: rtl/upcnt_prescaler.sv
// Step-rate prescaler: pulses tick_o once every Prescale cycles while run_i is high.
module upcnt_prescaler #(
  parameter int unsigned Prescale = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Prescale > 1) ? $clog2(Prescale) : 1;

  logic [CntW-1:0] pcnt_q, pcnt_d;

  assign tick_o = run_i && (pcnt_q == CntW'(Prescale - 1));

  always_comb begin
    pcnt_d = pcnt_q + CntW'(1);
    // Phase restarts whenever counting is interrupted so each RUN begins a full period.
    if (clr_i || !run_i || tick_o) begin
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/up_counter_tc.sv
// Loadable up counter with wrap or one-shot stop, registered tc pulse and done level.
// Optional step prescaler enabled by defining UPCNT_PRESCALE_EN.
module up_counter_tc
  import upcnt_pkg::*;
#(
  parameter int unsigned WIDTH    = UpcntDefaultWidth,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             one_shot_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] MaxCnt = '1;

  upcnt_state_t     state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             tick;

`ifdef UPCNT_PRESCALE_EN
  upcnt_prescaler #(
    .Prescale(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run_i (state_q == StRun),
    .clr_i (clr_i | load_i),
    .tick_o(tick)
  );
`else
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    if (clr_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else if (load_i) begin
      state_d = en_i ? StRun : StIdle;
      cnt_d   = load_val_i;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en_i) state_d = StRun;
        end
        StRun: begin
          if (!en_i) begin
            state_d = StIdle;
          end else if (tick) begin
            if (cnt_q != MaxCnt) begin
              cnt_d = cnt_q + WIDTH'(1);
            end else if (one_shot_i) begin
              tc_d    = 1'b1;
              done_d  = 1'b1;
              state_d = StDone;
            end else begin
              cnt_d = '0;
              tc_d  = 1'b1;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_up_counter_tc.sv
// Directed self-checking bench for up_counter_tc (WIDTH=4); prescaler case runs under
// UPCNT_PRESCALE_EN with PRESCALE=3.
module tb_up_counter_tc;

`ifdef UPCNT_PRESCALE_EN
  localparam int unsigned Prescale = 3;
`else
  localparam int unsigned Prescale = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, clr, load, one_shot;
  logic [3:0] load_val;
  logic [3:0] cnt;
  logic       tc, done;

  int checks   = 0;
  int failures = 0;

  up_counter_tc #(
    .WIDTH   (4),
    .PRESCALE(Prescale)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en),
    .clr_i     (clr),
    .load_i    (load),
    .load_val_i(load_val),
    .one_shot_i(one_shot),
    .cnt_o     (cnt),
    .tc_o      (tc),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] c, input logic t,
                            input logic d);
    check({tag, ".cnt"}, 32'(cnt), 32'(c));
    check({tag, ".tc"}, 32'(tc), 32'(t));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // Advance one edge and settle 1ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; one_shot = 1'b0; load_val = 4'h0;
    #2;
    expect_out("reset", 4'h0, 1'b0, 1'b0);
    #10;
    rst_n = 1'b1;
    en    = 1'b1;

    // 1: free run with wrap
    tick();
    expect_out("t1.enter_run", 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      expect_out($sformatf("t1.step%0d", i), 4'(i % 16), (i == 16), 1'b0);
    end
    tick();
    expect_out("t1.after_wrap", 4'h1, 1'b0, 1'b0);
    en = 1'b0;
    tick();
    expect_out("t1.en_drop", 4'h1, 1'b0, 1'b0);

    // 2: load near max, wrap mode
    load = 1'b1; load_val = 4'hD; en = 1'b1;
    tick();
    load = 1'b0;
    expect_out("t2.load", 4'hD, 1'b0, 1'b0);
    tick(); expect_out("t2.e", 4'hE, 1'b0, 1'b0);
    tick(); expect_out("t2.f", 4'hF, 1'b0, 1'b0);
    tick(); expect_out("t2.wrap", 4'h0, 1'b1, 1'b0);
    tick(); expect_out("t2.one", 4'h1, 1'b0, 1'b0);

    // 3: one-shot from C
    one_shot = 1'b1; load = 1'b1; load_val = 4'hC;
    tick();
    load = 1'b0;
    expect_out("t3.load", 4'hC, 1'b0, 1'b0);
    tick(); expect_out("t3.d", 4'hD, 1'b0, 1'b0);
    tick(); expect_out("t3.e", 4'hE, 1'b0, 1'b0);
    tick(); expect_out("t3.f", 4'hF, 1'b0, 1'b0);
    tick(); expect_out("t3.done", 4'hF, 1'b1, 1'b1);
    tick(); expect_out("t3.hold", 4'hF, 1'b0, 1'b1);
    en = 1'b0;
    tick(); expect_out("t3.ign_en", 4'hF, 1'b0, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    expect_out("t3.clr", 4'h0, 1'b0, 1'b0);

    // 4: async reset mid-cycle; IDLE after clr shown by one-edge start latency
    one_shot = 1'b0; en = 1'b1;
    tick(); expect_out("t4.enter_run", 4'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) tick();
    expect_out("t4.nine", 4'h9, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("t4.async_cnt", 32'(cnt), 32'h0);
    #2 rst_n = 1'b1;
    tick(); expect_out("t4.restart", 4'h0, 1'b0, 1'b0);
    tick(); expect_out("t4.first", 4'h1, 1'b0, 1'b0);

    // 5: en gaps, then clr beats load
    en = 1'b0;
    tick(); expect_out("t5.en0a", 4'h1, 1'b0, 1'b0);
    tick(); expect_out("t5.en0b", 4'h1, 1'b0, 1'b0);
    en = 1'b1;
    tick(); expect_out("t5.en1a", 4'h1, 1'b0, 1'b0);
    tick(); expect_out("t5.en1b", 4'h2, 1'b0, 1'b0);
    clr = 1'b1; load = 1'b1; load_val = 4'h7;
    tick();
    clr = 1'b0; load = 1'b0;
    expect_out("t5.clr_wins", 4'h0, 1'b0, 1'b0);
    tick(); expect_out("t5.idle_run", 4'h0, 1'b0, 1'b0);
    tick(); expect_out("t5.count", 4'h1, 1'b0, 1'b0);

    // Boundary: load MAX in one-shot, next step enters DONE; load exits DONE
    one_shot = 1'b1; load = 1'b1; load_val = 4'hF;
    tick();
    load = 1'b0;
    expect_out("b.load_max", 4'hF, 1'b0, 1'b0);
    tick(); expect_out("b.done", 4'hF, 1'b1, 1'b1);
    en = 1'b0; load = 1'b1; load_val = 4'h2;
    tick();
    load = 1'b0;
    expect_out("b.load_exit", 4'h2, 1'b0, 1'b0);
    tick(); expect_out("b.idle_hold", 4'h2, 1'b0, 1'b0);

`ifdef UPCNT_PRESCALE_EN
    // 6: prescaler, one step every 3 edges
    one_shot = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    tick(); expect_out("t6.enter_run", 4'h0, 1'b0, 1'b0);
    for (int e = 1; e <= 45; e++) begin
      tick();
      check($sformatf("t6.edge%0d", e), 32'(cnt), 32'(e / 3));
    end
    check("t6.tc_low", 32'(tc), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
